// File: rtl/bitwise_ser.sv
// rtl/bitwise_ser.sv - parallel-in, serial-out shifter driving a bitwise d/en link
//
// Purpose:
//   Takes one WIDTH-bit word through a load handshake.
//   Emits the word one bit per enabled clock on d.
//   Pulses done once the last bit has been consumed, so the source can
//   supply the next word.
//
// Parameters:
//   WIDTH      data word width in bits (2 or more)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Optional build macro:
//   BITWISE_SER_PARITY_EN  appends one even-parity bit after the data bits.
//                          The parity is latched when the word is loaded.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   load_en  in   load request, honoured only while ready=1
//   load     in   parallel word captured on load_en && ready
//   en       in   link shift enable; 0 stalls the current bit
//   ready    out  idle, a load will be accepted
//   busy     out  word in flight (always ~ready)
//   d        out  current serial bit (0 when idle)
//   d_valid  out  d is consumed this cycle
//   done     out  one-cycle pulse on return to idle after the final bit
module bitwise_ser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             en,
  output logic             ready,
  output logic             busy,
  output logic             d,
  output logic             d_valid,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef BITWISE_SER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef BITWISE_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // The bit on the wire is always taken from the output end of the register.
  // Shifting toward that end keeps the next bit lined up without a mux tree.
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef BITWISE_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef BITWISE_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef BITWISE_SER_PARITY_EN
    par_d   = par_q;
`endif
    ready   = 1'b0;
    d       = 1'b0;
    d_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // en is deliberately ignored here: nothing is on the wire.
        ready = 1'b1;
        if (load_en) begin
          shreg_d = load;
          cnt_d   = '0;
`ifdef BITWISE_SER_PARITY_EN
          par_d   = ^load;
`endif
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        d       = out_bit;
        d_valid = en;
        if (en) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
`ifdef BITWISE_SER_PARITY_EN
            state_d = S_PARITY;
`else
            // done is registered, so it lands in the first idle cycle.
            // This is the same cycle in which ready rises.
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef BITWISE_SER_PARITY_EN
      S_PARITY: begin
        d       = par_q;
        d_valid = en;
        if (en) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = ~ready;
  assign done = done_q;

`ifndef SYNTHESIS
  // done must coincide with the idle state, so that a held load_en can chain
  // the next word in that same cycle.
  a_done_idle: assert property (@(posedge clk) disable iff (!reset_n)
    done |-> ready);

  // The bit counter is cleared on every load and never passes the last bit.
  a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == S_SHIFT) |-> (cnt_q <= LAST_CNT));
`endif

endmodule
